// File: rtl/object_fetch_sequencer.sv
// Per-frame object buffer walker: rewinds the buffer cursor, fetches each stored object,
// drops zero-depth objects if enabled, and hands the others to the rasterizer over valid/ready.
package object_fetch_pkg;
    typedef struct packed {
        logic [7:0]  depth;
        logic [7:0]  id;
        logic [11:0] x;
        logic [11:0] y;
    } object_t;
endpackage

module object_fetch_sequencer
    import object_fetch_pkg::*;
#(
    parameter int SIZE            = 50,
    parameter bit CULL_ZERO_DEPTH = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_start,
    input  object_t                     buf_data_b,
    input  logic                        buf_read_end,
    output logic                        buf_next_frame,
    output logic                        buf_read_b,
    output logic                        obj_valid,
    input  logic                        obj_ready,
    output object_t                     obj_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(SIZE+1)-1:0]   obj_count
);

    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REWIND  = 3'd1,
        ST_FETCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] fetch_cnt_r;
    logic [CW-1:0] obj_count_r;
    object_t       obj_data_r;
    logic          next_frame_r;
    logic          obj_valid_r;
    logic          busy_r;
    logic          frame_done_r;
    logic          start_s;
    logic          read_s;
    logic          load_s;
    logic          accept_s;

    // Next-state and per-cycle strobes of the walk.
    always_comb begin
        state_s  = state_r;
        start_s  = 1'b0;
        read_s   = 1'b0;
        load_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    start_s = 1'b1;
                    state_s = ST_REWIND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REWIND: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                // The counter bound matters when the cursor cannot wrap up to SIZE.
                if (buf_read_end || (fetch_cnt_r == SIZE_C)) begin
                    state_s = ST_DONE;
                end else begin
                    read_s = 1'b1;
                    if (CULL_ZERO_DEPTH && (buf_data_b.depth == 8'd0)) begin
                        state_s = ST_FETCH;
                    end else begin
                        load_s  = 1'b1;
                        state_s = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                if (obj_ready) begin
                    accept_s = 1'b1;
                    state_s  = ST_FETCH;
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            next_frame_r <= 1'b0;
            obj_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            next_frame_r <= (state_s == ST_REWIND);
            obj_valid_r  <= (state_s == ST_PRESENT);
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_s == ST_DONE);
        end
    end

    // Object capture on the same edge that advances the buffer cursor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            obj_data_r <= '0;
        end else if (load_s) begin
            obj_data_r <= buf_data_b;
        end else begin
            obj_data_r <= obj_data_r;
        end
    end

    // Fetch counter bounds the walk; it is cleared when a new frame is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt_r <= '0;
        end else if (start_s) begin
            fetch_cnt_r <= '0;
        end else if (read_s && (fetch_cnt_r != SIZE_C)) begin
            fetch_cnt_r <= fetch_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            fetch_cnt_r <= fetch_cnt_r;
        end
    end

    // Handshake counter, saturating, held after the frame until the next start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            obj_count_r <= '0;
        end else if (start_s) begin
            obj_count_r <= '0;
        end else if (accept_s && (obj_count_r != SIZE_C)) begin
            obj_count_r <= obj_count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            obj_count_r <= obj_count_r;
        end
    end

    assign buf_next_frame = next_frame_r;
    assign buf_read_b     = read_s;
    assign obj_valid      = obj_valid_r;
    assign obj_data       = obj_data_r;
    assign busy           = busy_r;
    assign frame_done     = frame_done_r;
    assign obj_count      = obj_count_r;

endmodule

// File: tb/tb_object_fetch_sequencer.sv
// Directed bench for object_fetch_sequencer with SIZE=4 and a behavioural object buffer.
module tb_object_fetch_sequencer;
    import object_fetch_pkg::*;

    localparam int SIZE = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        obj_ready = 1'b0;
    object_t     buf_data_b;
    logic        buf_read_end;
    logic        buf_next_frame;
    logic        buf_read_b;
    logic        obj_valid;
    object_t     obj_data;
    logic        busy;
    logic        frame_done;
    logic [2:0]  obj_count;

    object_t     mem [0:15];
    logic [3:0]  rd_ptr;
    logic [3:0]  wr_ptr = 4'd0;

    int errors = 0;
    int checks = 0;
    int reads = 0;
    int rewinds = 0;
    int dones = 0;
    logic [7:0] acc_ids [$];

    object_fetch_sequencer #(.SIZE(SIZE), .CULL_ZERO_DEPTH(1'b1)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .buf_data_b(buf_data_b), .buf_read_end(buf_read_end),
        .buf_next_frame(buf_next_frame), .buf_read_b(buf_read_b),
        .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_data(obj_data),
        .busy(busy), .frame_done(frame_done), .obj_count(obj_count)
    );

    always #5 clock = ~clock;

    // Behavioural object buffer read port
    assign buf_data_b   = mem[rd_ptr];
    assign buf_read_end = (rd_ptr == wr_ptr);
    always @(posedge clock or posedge reset) begin
        if (reset) rd_ptr <= 4'd0;
        else if (buf_next_frame) rd_ptr <= 4'd0;
        else if (buf_read_b) rd_ptr <= rd_ptr + 4'd1;
    end

    // Event monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (buf_read_b) reads <= reads + 1;
            if (buf_next_frame) rewinds <= rewinds + 1;
            if (frame_done) dones <= dones + 1;
            if (obj_valid && obj_ready) acc_ids.push_back(obj_data.id);
        end
    end

    typedef struct {
        logic [1:0] setup;
        logic       fs;
        logic       rdy;
        logic       nf;
        logic       rb;
        logic       v;
        logic [7:0] id;
        logic       bsy;
        logic       done;
        logic [2:0] cnt;
    } vec_t;
    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input int idx, input logic [7:0] depth, input logic [7:0] id);
        object_t o;
        o.depth = depth;
        o.id    = id;
        o.x     = 12'(idx * 16);
        o.y     = 12'(idx * 3 + 7);
        mem[idx] = o;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (obj_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin : main
        bit ok;
        int base_r;
        int base_i;
        int base_nf;
        int base_d;

        clear_mem();
        // setup 1 = empty buffer, setup 2 = objects with depth 1,2,3
        tbl[0]  = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd0};
        tbl[1]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd0};
        tbl[5]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 3'd0};
        tbl[7]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 3'd1};
        tbl[8]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 3'd1};
        tbl[9]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 3'd2};
        tbl[10] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 3'd2};
        tbl[11] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd3};
        tbl[12] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 3'd3};
        tbl[13] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 3'd3};

        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", {buf_next_frame, buf_read_b, obj_valid, busy, frame_done, obj_count}, 64'd0);
        check("reset_data", obj_data, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].setup == 2'd1) wr_ptr = 4'd0;
            if (tbl[i].setup == 2'd2) begin
                put(0, 8'd1, 8'd1); put(1, 8'd2, 8'd2); put(2, 8'd3, 8'd3);
                wr_ptr = 4'd3;
            end
            frame_start = tbl[i].fs;
            obj_ready   = tbl[i].rdy;
            tick();
            frame_start = 1'b0;
            check($sformatf("tbl%0d_next_frame", i), buf_next_frame, tbl[i].nf);
            check($sformatf("tbl%0d_read_b", i), buf_read_b, tbl[i].rb);
            check($sformatf("tbl%0d_valid", i), obj_valid, tbl[i].v);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            check($sformatf("tbl%0d_done", i), frame_done, tbl[i].done);
            check($sformatf("tbl%0d_count", i), obj_count, tbl[i].cnt);
            if (tbl[i].v) check($sformatf("tbl%0d_id", i), obj_data.id, tbl[i].id);
        end

        // Culling: depths 1,0,3,0
        clear_mem();
        put(0, 8'd1, 8'd1); put(1, 8'd0, 8'd2); put(2, 8'd3, 8'd3); put(3, 8'd0, 8'd4);
        wr_ptr = 4'd4;
        @(negedge clock);
        base_r = reads; base_i = acc_ids.size();
        obj_ready = 1'b1;
        start_frame();
        run_until_done(40, ok);
        check("cull_done", ok, 1'b1);
        check("cull_reads", reads - base_r, 4);
        check("cull_presented", acc_ids.size() - base_i, 2);
        if (acc_ids.size() - base_i == 2) begin
            check("cull_first_id", acc_ids[base_i], 8'd1);
            check("cull_second_id", acc_ids[base_i+1], 8'd3);
        end
        check("cull_count", obj_count, 3'd2);

        // Stall: rasterizer holds ready low for 10 cycles on object 1
        clear_mem();
        put(0, 8'd5, 8'd1); put(1, 8'd6, 8'd2);
        wr_ptr = 4'd2;
        obj_ready = 1'b0;
        tick();
        start_frame();
        wait_valid(10, ok);
        check("stall_valid_seen", ok, 1'b1);
        base_r = reads;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("stall_hold%0d", i), {obj_valid, buf_read_b, obj_data}, {1'b1, 1'b0, mem[0]});
        end
        check("stall_no_reads", reads - base_r, 0);
        base_i = acc_ids.size();
        obj_ready = 1'b1;
        run_until_done(40, ok);
        check("stall_done", ok, 1'b1);
        check("stall_presented", acc_ids.size() - base_i, 2);
        if (acc_ids.size() - base_i == 2) check("stall_first_id", acc_ids[base_i], 8'd1);
        check("stall_count", obj_count, 3'd2);

        // Full buffer: cursor never meets the write cursor; frame_start mid-walk is ignored
        clear_mem();
        for (int i = 0; i < 4; i++) put(i, 8'd9, 8'(i + 1));
        wr_ptr = 4'd15;
        @(negedge clock);
        base_r = reads; base_nf = rewinds; base_d = dones; base_i = acc_ids.size();
        obj_ready = 1'b1;
        start_frame();
        repeat (3) tick();
        start_frame();
        run_until_done(40, ok);
        check("full_done", ok, 1'b1);
        check("full_reads", reads - base_r, 4);
        check("full_count", obj_count, 3'd4);
        check("full_presented", acc_ids.size() - base_i, 4);
        repeat (5) tick();
        check("full_idle_after", busy, 1'b0);
        check("full_one_rewind", rewinds - base_nf, 1);
        check("full_one_done", dones - base_d, 1);

        // Asynchronous reset while presenting, then a clean restart
        clear_mem();
        put(0, 8'd7, 8'd1); put(1, 8'd8, 8'd2);
        wr_ptr = 4'd2;
        obj_ready = 1'b0;
        start_frame();
        wait_valid(10, ok);
        check("rst_valid_seen", ok, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", {buf_next_frame, buf_read_b, obj_valid, busy, frame_done, obj_count}, 64'd0);
        check("rst_async_data", obj_data, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        obj_ready = 1'b1;
        start_frame();
        check("rst_restart_rewind", {buf_next_frame, busy}, 2'b11);
        tick();
        check("rst_restart_fetch", {buf_next_frame, buf_read_b}, 2'b01);
        run_until_done(40, ok);
        check("rst_restart_done", ok, 1'b1);
        check("rst_restart_count", obj_count, 3'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
